// File: rtl/alu_sort_ctrl.sv
// alu_sort_ctrl: bubble-sort sequencer that sits in front of an 8-bit alu.
// A host loads the array and starts the sort. The block then walks adjacent
// pairs (array[i], array[i+1]) into the alu with A-B selected. It reads back
// the Zero/Negative flags and swaps the pair when A > B. A pass that makes no
// swap ends the sort early.
//
// Ports:
//   sClk, sReset                  clock, async active-high reset
//   sLoadEn/sLoadAddr/sLoadData   array write (IDLE only)
//   sStart                        begin sort (IDLE only)
//   sReadAddr -> sReadData        combinational array readback
//   sBusy, sDone                  busy in CMP/SWAP, one-cycle done pulse
//   sAluA, sAluB, sAluSel         operand/select drive to the alu
//   sAluZero, sAluNegative        alu flags for the current pair
module alu_sort_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int SELECTION = 3,
  parameter int DEPTH     = 8,
  parameter int ADDRWIDTH = 3
) (
  input  logic                 sClk,
  input  logic                 sReset,
  input  logic                 sLoadEn,
  input  logic [ADDRWIDTH-1:0] sLoadAddr,
  input  logic [DATAWIDTH-1:0] sLoadData,
  input  logic                 sStart,
  input  logic [ADDRWIDTH-1:0] sReadAddr,
  output logic [DATAWIDTH-1:0] sReadData,
  output logic                 sBusy,
  output logic                 sDone,
  output logic [DATAWIDTH-1:0] sAluA,
  output logic [DATAWIDTH-1:0] sAluB,
  output logic [SELECTION-1:0] sAluSel,
  input  logic                 sAluZero,
  input  logic                 sAluNegative
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_SWAP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDRWIDTH-1:0] LAST     = ADDRWIDTH'(DEPTH - 1);
  localparam logic [SELECTION-1:0] SEL_PASS = '0;
  localparam logic [SELECTION-1:0] SEL_SUB  = SELECTION'(1);

  logic [DATAWIDTH-1:0] r_mem [DEPTH];
  logic [1:0]           r_state;
  logic [ADDRWIDTH-1:0] r_i;
  logic [ADDRWIDTH-1:0] r_bound;
  logic                 r_swapped;

  logic [ADDRWIDTH-1:0] w_ip1;
  logic                 w_swap_needed;
  logic                 w_pass_end;
  logic                 w_finish;
  logic [1:0]           w_adv_state;
  logic [ADDRWIDTH-1:0] w_adv_i;
  logic [ADDRWIDTH-1:0] w_adv_bound;
  logic                 w_adv_clr;

  assign w_ip1         = r_i + 1'b1;
  // A > B exactly when the difference is neither zero nor negative.
  // Equal pairs are never swapped, which keeps the sort stable.
  assign w_swap_needed = !sAluZero && !sAluNegative;
  assign w_pass_end    = (r_i == r_bound - 1'b1);
  // In SWAP, the swap being committed this cycle counts toward the pass
  // even though r_swapped only updates at this edge.
  assign w_finish      = !(r_swapped || (r_state == S_SWAP)) || (r_bound == 1);

  // Next-step decision shared by CMP (no swap) and SWAP: either step to the
  // next pair, or close the pass by shrinking the bound or finishing.
  always_comb begin
    w_adv_state = S_CMP;
    w_adv_i     = w_ip1;
    w_adv_bound = r_bound;
    w_adv_clr   = 1'b0;
    if (w_pass_end) begin
      if (w_finish) begin
        w_adv_state = S_DONE;
        w_adv_i     = r_i;
      end else begin
        w_adv_i     = '0;
        w_adv_bound = r_bound - 1'b1;
        w_adv_clr   = 1'b1;
      end
    end
  end

  always_ff @(posedge sClk or posedge sReset) begin
    if (sReset) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_bound   <= LAST;
      r_swapped <= 1'b0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sLoadEn) r_mem[sLoadAddr] <= sLoadData;
          if (sStart) begin
            r_i       <= '0;
            r_bound   <= LAST;
            r_swapped <= 1'b0;
            r_state   <= S_CMP;
          end
        end
        S_CMP: begin
          if (w_swap_needed) begin
            r_state <= S_SWAP;
          end else begin
            r_state <= w_adv_state;
            r_i     <= w_adv_i;
            r_bound <= w_adv_bound;
            if (w_adv_clr) r_swapped <= 1'b0;
          end
        end
        S_SWAP: begin
          r_mem[r_i]   <= r_mem[w_ip1];
          r_mem[w_ip1] <= r_mem[r_i];
          r_swapped    <= ~w_adv_clr;
          r_state      <= w_adv_state;
          r_i          <= w_adv_i;
          r_bound      <= w_adv_bound;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sReadData = r_mem[sReadAddr];
  assign sAluA     = r_mem[r_i];
  assign sAluB     = r_mem[w_ip1];
  assign sAluSel   = (r_state == S_CMP) ? SEL_SUB : SEL_PASS;
  assign sBusy     = (r_state == S_CMP) || (r_state == S_SWAP);
  assign sDone     = (r_state == S_DONE);

endmodule

// File: tb/tb_alu_sort_ctrl.sv
module tb_alu_sort_ctrl;

  logic       sClk, sReset, sLoadEn, sStart;
  logic [2:0] sLoadAddr, sReadAddr, sAluSel;
  logic [7:0] sLoadData, sReadData, sAluA, sAluB;
  logic       sBusy, sDone, sAluZero, sAluNegative;

  alu_sort_ctrl #(.DATAWIDTH(8), .SELECTION(3), .DEPTH(8), .ADDRWIDTH(3)) dut (
    .sClk(sClk), .sReset(sReset), .sLoadEn(sLoadEn), .sLoadAddr(sLoadAddr),
    .sLoadData(sLoadData), .sStart(sStart), .sReadAddr(sReadAddr),
    .sReadData(sReadData), .sBusy(sBusy), .sDone(sDone), .sAluA(sAluA),
    .sAluB(sAluB), .sAluSel(sAluSel), .sAluZero(sAluZero),
    .sAluNegative(sAluNegative)
  );

  // Minimal alu: 001 = A-B, 000 = pass A.
  logic [7:0] w_diff;
  assign w_diff       = sAluA - sAluB;
  assign sAluZero     = (sAluSel == 3'b001) ? (w_diff == 8'd0) : (sAluA == 8'd0);
  assign sAluNegative = (sAluSel == 3'b001) ? w_diff[7] : sAluA[7];

  initial sClk = 1'b0;
  always #5 sClk = ~sClk;

  localparam int K_DONE = 0, K_READ = 1, K_STAT = 2;
  typedef struct {int kind; int addr; int val; int busy; int cmps;} exp_t;
  exp_t q[$];

  int   n_cmp = 0, n_bad = 0;
  logic rd_req = 1'b0;
  int   arr[8];
  int   exp_arr[8];

  // Monitor: counts busy/compare cycles, spots a swap right after an equal
  // compare, and pops the scoreboard on every done pulse or read strobe.
  initial begin
    int busy_cnt, cmp_cnt, eq_bad;
    bit prev_eq, prev_busy;
    exp_t e;
    busy_cnt = 0; cmp_cnt = 0; eq_bad = 0; prev_eq = 0; prev_busy = 0;
    forever begin
      @(negedge sClk);
      if (sReset) begin
        busy_cnt = 0; cmp_cnt = 0; eq_bad = 0; prev_eq = 0; prev_busy = 0;
      end
      if (sBusy) begin
        busy_cnt++;
        if (sAluSel == 3'b001) cmp_cnt++;
        else if (prev_eq) eq_bad++;
      end
      if (sDone) begin
        n_cmp++;
        if (q.size() == 0 || q[0].kind != K_DONE) begin
          n_bad++;
          $display("FAIL done_pulse: unexpected done (busy=%0d) required no done", busy_cnt);
        end else begin
          e = q.pop_front();
          if (busy_cnt != e.busy || cmp_cnt != e.cmps || eq_bad != 0 || !prev_busy) begin
            n_bad++;
            $display("FAIL done_stats: busy=%0d cmps=%0d eqswap=%0d busy_before=%0b required busy=%0d cmps=%0d eqswap=0 busy_before=1",
                     busy_cnt, cmp_cnt, eq_bad, prev_busy, e.busy, e.cmps);
          end
        end
        busy_cnt = 0; cmp_cnt = 0; eq_bad = 0;
      end
      if (rd_req) begin
        n_cmp++;
        if (q.size() == 0 || q[0].kind == K_DONE) begin
          n_bad++;
          $display("FAIL read_order: check strobe with no matching expectation (q=%0d)", q.size());
        end else begin
          e = q.pop_front();
          if (e.kind == K_READ && sReadData != e.val[7:0]) begin
            n_bad++;
            $display("FAIL read[%0d]: got %0d required %0d", e.addr, sReadData, e.val);
          end else if (e.kind == K_STAT && (sBusy || sDone || sAluSel != 3'b000)) begin
            n_bad++;
            $display("FAIL status: busy=%0b done=%0b sel=%b required 0 0 000", sBusy, sDone, sAluSel);
          end
        end
      end
      prev_eq   = sBusy && (sAluSel == 3'b001) && (sAluA == sAluB);
      prev_busy = sBusy;
    end
  end

  task automatic tick();
    @(posedge sClk); #1;
  endtask

  task automatic chk(input int kind, input int a, input int v);
    exp_t e;
    e.kind = kind; e.addr = a; e.val = v; e.busy = 0; e.cmps = 0;
    q.push_back(e);
    sReadAddr = 3'(a);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic load_all();
    for (int k = 0; k < 8; k++) begin
      sLoadEn = 1'b1; sLoadAddr = 3'(k); sLoadData = 8'(arr[k]);
      tick();
    end
    sLoadEn = 1'b0;
  endtask

  task automatic start(input bit expect_done, input int busy, input int cmps);
    exp_t e;
    if (expect_done) begin
      e.kind = K_DONE; e.addr = 0; e.val = 0; e.busy = busy; e.cmps = cmps;
      q.push_back(e);
    end
    sStart = 1'b1;
    tick();
    sStart = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (sDone) seen = 1;
      else tick();
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done within 300 cycles");
    end
  endtask

  task automatic read_all();
    for (int k = 0; k < 8; k++) chk(K_READ, k, exp_arr[k]);
  endtask

  initial begin
    sReset = 1'b1; sLoadEn = 1'b0; sStart = 1'b0;
    sLoadAddr = '0; sLoadData = '0; sReadAddr = '0;
    tick();
    // Reset state
    chk(K_STAT, 0, 0);
    chk(K_READ, 0, 0);
    chk(K_READ, 7, 0);
    sReset = 1'b0;
    tick();

    // 1: already sorted -> 7 compares, no swaps
    arr = '{1, 2, 3, 4, 5, 6, 7, 8}; exp_arr = arr;
    load_all(); start(1, 7, 7); wait_done(); read_all();

    // 2: reverse order -> 28 compares + 28 swaps
    arr = '{8, 7, 6, 5, 4, 3, 2, 1}; exp_arr = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_all(); start(1, 56, 28); wait_done(); read_all();

    // 3: duplicates and the top of the operand range
    arr = '{5, 3, 5, 0, 127, 3, 1, 0}; exp_arr = '{0, 0, 1, 3, 3, 5, 5, 127};
    load_all(); start(1, 46, 28); wait_done(); read_all();

    // 4: start + load mid-sort are ignored
    arr = '{8, 7, 6, 5, 4, 3, 2, 1}; exp_arr = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_all(); start(1, 56, 28);
    repeat (9) tick();
    sStart = 1'b1; sLoadEn = 1'b1; sLoadAddr = 3'd0; sLoadData = 8'd99;
    tick();
    sStart = 1'b0; sLoadEn = 1'b0;
    wait_done(); read_all();

    // 5: asynchronous reset mid-sort, then a fresh sort
    load_all(); start(0, 0, 0);
    repeat (19) tick();
    #1 sReset = 1'b1;
    chk(K_STAT, 0, 0);
    exp_arr = '{0, 0, 0, 0, 0, 0, 0, 0};
    read_all();
    sReset = 1'b0;
    tick();
    arr = '{1, 2, 3, 4, 5, 6, 8, 7}; exp_arr = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_all(); start(1, 14, 13); wait_done(); read_all();

    // 6: all equal -> single pass, no swaps
    arr = '{42, 42, 42, 42, 42, 42, 42, 42}; exp_arr = arr;
    load_all(); start(1, 7, 7); wait_done(); read_all();

    repeat (3) tick();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
